// File: rtl/tlul_pkg.sv
// TL-UL channel struct types shared by hosts and devices on the crossbar.
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_scratchpad_pkg.sv
// Shared types and helpers for the TL-UL scratchpad device.
package tlul_scratchpad_pkg;

  // A-channel opcodes the device understands
  localparam logic [2:0] OpPutFullData    = 3'd0;
  localparam logic [2:0] OpPutPartialData = 3'd1;
  localparam logic [2:0] OpGet            = 3'd4;

  // D-channel opcodes the device returns
  localparam logic [2:0] OpAccessAck      = 3'd0;
  localparam logic [2:0] OpAccessAckData  = 3'd1;

  // One queued response; everything the D channel needs
  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] data;
    logic        error;
  } rsp_entry_t;

  // Byte lanes covered by an access of the given size at the given offset
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] addr_lsb);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001 << addr_lsb;
      2'd1:    m = addr_lsb[1] ? 4'b1100 : 4'b0011;
      2'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tlul_scratchpad_rsp_fifo.sv
// Response FIFO: holds one entry per accepted A beat until the D beat is taken.
module tlul_scratchpad_rsp_fifo
  import tlul_scratchpad_pkg::*;
#(
  parameter int Depth = 2,
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CW = $clog2(Depth + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  rsp_entry_t      i_wdata,
  input  logic            i_pop,
  output rsp_entry_t      o_rdata,
  output logic            o_full,
  output logic            o_empty,
  output logic [CW-1:0]   o_count
);

  rsp_entry_t      r_mem [Depth];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CW'(Depth));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Pointers and occupancy; pointers wrap at Depth so any depth 1..4 works
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(Depth - 1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PW'(Depth - 1)) ? '0 : r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the slot is empty
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/tlul_scratchpad.sv
// TL-UL scratchpad device: word memory, protocol error checking, in-order
// responses one cycle after acceptance.
// Optional build macro TLUL_SCRATCHPAD_ERR_LOG_EN adds err_count_o/err_addr_o.
module tlul_scratchpad
  import tlul_scratchpad_pkg::*;
#(
  parameter string       MemInitFile = "",
  parameter int          Depth       = 4096,
  parameter logic [31:0] BaseAddr    = 32'h0010_0000,
  parameter int          Outstanding = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tlul_pkg::tl_h2d_t tl_i,
`ifdef TLUL_SCRATCHPAD_ERR_LOG_EN
  output tlul_pkg::tl_d2h_t tl_o,
  output logic [7:0]        err_count_o,
  output logic [31:0]       err_addr_o
`else
  output tlul_pkg::tl_d2h_t tl_o
`endif
);

  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(Outstanding + 1);

  logic [31:0]   r_mem [Depth];

  logic [31:0]   w_offset;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_lanes;
  logic          w_is_get;
  logic          w_is_put;
  logic          w_err;
  logic          w_fire;
  logic          w_we;
  logic [31:0]   w_rdata;
  rsp_entry_t    w_push_entry;
  rsp_entry_t    w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_unused_count;
  logic          w_unused_tl;

  assign w_unused_tl = ^{tl_i.a_param, tl_i.a_user};

  assign w_offset   = tl_i.a_address - BaseAddr;
  assign w_in_range = (tl_i.a_address >= BaseAddr) && (w_offset < 32'(4 * Depth));
  assign w_idx      = w_offset[AW+1:2];
  assign w_lanes    = lane_mask(tl_i.a_size, tl_i.a_address[1:0]);
  assign w_is_get   = (tl_i.a_opcode == OpGet);
  assign w_is_put   = (tl_i.a_opcode == OpPutFullData) ||
                      (tl_i.a_opcode == OpPutPartialData);

  // Any protocol violation turns the request into an error response
  always_comb begin
    w_err = 1'b0;
    if (!w_is_get && !w_is_put)                              w_err = 1'b1;
    if (!w_in_range)                                         w_err = 1'b1;
    if (tl_i.a_size > 2'd2)                                  w_err = 1'b1;
    if (tl_i.a_size == 2'd2 && tl_i.a_address[1:0] != 2'b00) w_err = 1'b1;
    if (tl_i.a_size == 2'd1 && tl_i.a_address[0])            w_err = 1'b1;
    if (tl_i.a_opcode == OpPutFullData && tl_i.a_mask != w_lanes)
      w_err = 1'b1;
    if (tl_i.a_opcode == OpPutPartialData && (tl_i.a_mask & ~w_lanes) != 4'b0000)
      w_err = 1'b1;
  end

  // a_ready depends only on FIFO occupancy, never on d_ready
  assign w_fire  = tl_i.a_valid & ~w_full;
  assign w_we    = w_fire & w_is_put & ~w_err;
  assign w_rdata = r_mem[w_idx];

  // Byte-lane write; memory is deliberately not reset
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (tl_i.a_mask[b]) r_mem[w_idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
      end
    end
  end

  // Response captured at acceptance; read data sampled in the same edge
  always_comb begin
    w_push_entry        = '0;
    w_push_entry.opcode = w_is_get ? OpAccessAckData : OpAccessAck;
    w_push_entry.size   = tl_i.a_size;
    w_push_entry.source = tl_i.a_source;
    w_push_entry.data   = (w_is_get && !w_err) ? w_rdata : 32'h0;
    w_push_entry.error  = w_err;
  end

  tlul_scratchpad_rsp_fifo #(
    .Depth (Outstanding)
  ) u_rsp_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_fire),
    .i_wdata (w_push_entry),
    .i_pop   (tl_i.d_ready),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_unused_count)
  );

  // D channel driven from the FIFO head; all fields zero while empty
  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = ~w_full;
    if (!w_empty) begin
      tl_o.d_valid  = 1'b1;
      tl_o.d_opcode = w_head.opcode;
      tl_o.d_size   = w_head.size;
      tl_o.d_source = w_head.source;
      tl_o.d_data   = w_head.data;
      tl_o.d_error  = w_head.error;
    end
  end

`ifdef TLUL_SCRATCHPAD_ERR_LOG_EN
  logic [7:0]  r_err_count;
  logic [31:0] r_err_addr;

  // Count error responses as they are pushed, saturating at 255
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else if (w_fire && w_err) begin
      if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      r_err_addr <= tl_i.a_address;
    end
  end

  assign err_count_o = r_err_count;
  assign err_addr_o  = r_err_addr;
`endif

endmodule
